// File: rtl/vram_access_arbiter.sv
// ----------------------------------------------------------------------------
// vram_access_arbiter
//
// Purpose:
//   Shares one single-port synchronous video RAM between the VGA scanout
//   and a drawing/game-logic writer. Scanout reads win every slot they
//   claim. Writer requests are buffered in a small FIFO, and the FIFO
//   drains into every slot that scanout does not use.
//
// Ports:
//   clk          system clock (50 MHz)
//   Reset        asynchronous, active-high reset
//   pix_en       one-clk pulse per pixel from the sync generator
//   disp_active  scanout is inside the visible area
//   scan_addr    pixel address to read in this pixel slot
//   wr_valid     writer request valid
//   wr_ready     FIFO can accept a request (not full)
//   wr_addr      writer address
//   wr_data      writer data
//   mem_addr     VRAM address (registered)
//   mem_we       VRAM write enable (registered)
//   mem_wdata    VRAM write data (registered)
//   mem_rdata    VRAM read data, valid one clk after mem_addr
//   pix_data     captured pixel for the RGB stage
//   pix_valid    one-clk pulse when pix_data updates
//   fifo_level   number of queued write requests
// ----------------------------------------------------------------------------
module vram_access_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          pix_en,
    input  logic                          disp_active,
    input  logic [ADDR_W-1:0]             scan_addr,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [DATA_W-1:0]             pix_data,
    output logic                          pix_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Slot FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // ------------------------------------------------------------------
    // Write FIFO state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic scan_req;

    // ------------------------------------------------------------------
    // Slot / memory-port state
    // ------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // ------------------------------------------------------------------
    // Read-return pipeline state
    // ------------------------------------------------------------------
    logic              rd_pend_q,   rd_pend_d;
    logic [DATA_W-1:0] pix_data_q,  pix_data_d;
    logic              pix_valid_q, pix_valid_d;

    // Full/empty come from the registered level only, so a pop at the same
    // edge cannot make room for a push into a full FIFO.
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);

    assign scan_req = pix_en & disp_active;
    assign pop      = ~scan_req & ~fifo_empty;
    assign push     = wr_valid & ~fifo_full;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Pointers are PTR_W bits wide, so increments wrap modulo depth.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage carries no reset: entries are only ever read behind the
    // read pointer, and the reset clears the level that guards them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Grant decision: scanout first, then the FIFO head, otherwise idle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = ST_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        if (scan_req) begin
            state_d    = ST_SCAN;
            mem_addr_d = scan_addr;
        end else if (pop) begin
            state_d     = ST_WRITE;
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
            mem_we_d    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read return: the SCAN slot presents its address after E0, the RAM
    // answers after E1, and the pixel is captured at E2.
    // ------------------------------------------------------------------
    always_comb begin
        rd_pend_d   = (state_q == ST_SCAN);
        pix_valid_d = rd_pend_q;
        pix_data_d  = pix_data_q;
        if (rd_pend_q) begin
            pix_data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign wr_ready   = ~fifo_full;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
module tb_vram_access_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              Reset;
    logic              pix_en;
    logic              disp_active;
    logic [ADDR_W-1:0] scan_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic [2:0]        fifo_level;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]        ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W+DATA_W-1:0] wlog [$];

    vram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .disp_active (disp_active),
        .scan_addr   (scan_addr),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .fifo_level  (fifo_level)
    );

    always #10 clk = ~clk;

    // Single-port synchronous RAM model plus a log of every write it sees.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pix_en      = 1'b0;
        disp_active = 1'b0;
        wr_valid    = 1'b0;
        scan_addr   = '0;
        wr_addr     = '0;
        wr_data     = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        #25;
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
        checks++;
        if ({mem_we, pix_valid} !== 2'b00) begin errors++; $display("FAIL reset_we_pv got=%b exp=00", {mem_we, pix_valid}); end
        checks++;
        if ({mem_addr, mem_wdata, pix_data} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, pix_data}); end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        wlog.delete();
        wr_valid = 1'b1; wr_addr = 15'h0010; wr_data = 8'hA5;
        step();                       // E0: accepted, not bypassed
        wr_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL single_accept we=%b lvl=%0d exp we=0 lvl=1", mem_we, fifo_level);
        end
        step();                       // E1: issued
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h0010 || mem_wdata !== 8'hA5) begin
            errors++; $display("FAIL single_issue we=%b addr=%h data=%h exp 1/0010/a5", mem_we, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (mem_we !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL single_done we=%b lvl=%0d exp we=0 lvl=0", mem_we, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] exp_a [3];
        exp_a[0] = 15'h0021; exp_a[1] = 15'h0022; exp_a[2] = 15'h0023;
        for (int k = 0; k < 4; k++) begin
            wr_valid = (k < 3);
            if (k < 3) begin wr_addr = exp_a[k]; wr_data = 8'h60 + 8'(k); end
            step();
            if (k > 0) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== exp_a[k-1] || mem_wdata !== 8'h60 + 8'(k-1)) begin
                    errors++; $display("FAIL b2b_issue%0d we=%b addr=%h data=%h exp addr=%h", k, mem_we, mem_addr, mem_wdata, exp_a[k-1]);
                end
            end
        end
        wr_valid = 1'b0;
        step();
        checks++;
        if (mem_we !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL b2b_done we=%b lvl=%0d exp 0/0", mem_we, fifo_level);
        end
    endtask

    task automatic test_scan_read();
        // Place 0x3C at 0x1234 through the writer port during blanking.
        wr_valid = 1'b1; wr_addr = 15'h1234; wr_data = 8'h3C;
        step();
        wr_valid = 1'b0;
        step();
        step();
        disp_active = 1'b1; pix_en = 1'b1; scan_addr = 15'h1234;
        step();                       // E0
        pix_en = 1'b0; scan_addr = 15'h0777;
        checks++;
        if (mem_addr !== 15'h1234 || mem_we !== 1'b0 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL scan_e0 addr=%h we=%b pv=%b exp 1234/0/0", mem_addr, mem_we, pix_valid);
        end
        step();                       // E1
        checks++;
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL scan_e1 pv=%b exp=0", pix_valid); end
        step();                       // E2
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 8'h3C) begin
            errors++; $display("FAIL scan_e2 pv=%b pix=%h exp 1/3c", pix_valid, pix_data);
        end
        step();
        checks++;
        if (pix_valid !== 1'b0 || pix_data !== 8'h3C) begin
            errors++; $display("FAIL scan_hold pv=%b pix=%h exp 0/3c", pix_valid, pix_data);
        end
        disp_active = 1'b0;
    endtask

    task automatic test_scan_priority();
        wlog.delete();
        disp_active = 1'b1; pix_en = 1'b1; scan_addr = 15'h0055;
        wr_valid = 1'b1; wr_addr = 15'h0200; wr_data = 8'h11;
        step();
        wr_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL prio_push we=%b lvl=%0d exp 0/1", mem_we, fifo_level);
        end
        step();                       // FIFO non-empty, scan still wins
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 15'h0055 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL prio_scan we=%b addr=%h lvl=%0d exp 0/0055/1", mem_we, mem_addr, fifo_level);
        end
        pix_en = 1'b0;
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h0200 || mem_wdata !== 8'h11 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL prio_write we=%b addr=%h data=%h lvl=%0d exp 1/0200/11/0", mem_we, mem_addr, mem_wdata, fifo_level);
        end
        disp_active = 1'b0;
        step();
        step();
    endtask

    task automatic test_interleave();
        wlog.delete();
        disp_active = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pix_en    = (k % 2 == 0);
            scan_addr = 15'h0100 + 15'(k);
            wr_valid  = (k < 4);
            wr_addr   = 15'h0400 + 15'(k);
            wr_data   = 8'h50 + 8'(k);
            step();
            checks++;
            if (mem_we !== (k % 2 == 1)) begin
                errors++; $display("FAIL ilv_we%0d got=%b exp=%b", k, mem_we, (k % 2 == 1));
            end
            if (pix_en) begin
                checks++;
                if (mem_addr !== scan_addr) begin
                    errors++; $display("FAIL ilv_scan%0d addr=%h exp=%h", k, mem_addr, scan_addr);
                end
            end
            checks++;
            if (pix_valid !== (k >= 2 && k % 2 == 0)) begin
                errors++; $display("FAIL ilv_pv%0d got=%b exp=%b", k, pix_valid, (k >= 2 && k % 2 == 0));
            end
        end
        pix_en = 1'b0; wr_valid = 1'b0; disp_active = 1'b0;
        step();
        checks++;
        if (wlog.size() != 4 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL ilv_count writes=%0d lvl=%0d exp 4/0", wlog.size(), fifo_level);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wlog[i] !== {15'h0400 + 15'(i), 8'h50 + 8'(i)}) begin
                    errors++; $display("FAIL ilv_order%0d got=%h exp=%h", i, wlog[i], {15'h0400 + 15'(i), 8'h50 + 8'(i)});
                end
            end
        end
    endtask

    task automatic test_full();
        wlog.delete();
        disp_active = 1'b1; pix_en = 1'b1; scan_addr = 15'h0066;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_addr = 15'h0300 + 15'(k); wr_data = 8'h40 + 8'(k);
            step();
        end
        checks++;
        if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL full_fill lvl=%0d rdy=%b exp 4/0", fifo_level, wr_ready);
        end
        wr_addr = 15'h0304; wr_data = 8'h44;
        step();                       // refused while full
        checks++;
        if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL full_refuse lvl=%0d rdy=%b exp 4/0", fifo_level, wr_ready);
        end
        pix_en = 1'b0;
        step();                       // pop, simultaneous push still refused
        checks++;
        if (fifo_level !== 3'd3 || wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h0300) begin
            errors++; $display("FAIL full_pop lvl=%0d rdy=%b we=%b addr=%h exp 3/1/1/0300", fifo_level, wr_ready, mem_we, mem_addr);
        end
        pix_en = 1'b1;
        step();                       // 5th accepted
        wr_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || mem_we !== 1'b0) begin
            errors++; $display("FAIL full_accept5 lvl=%0d we=%b exp 4/0", fifo_level, mem_we);
        end
        pix_en = 1'b0; disp_active = 1'b0;
        repeat (5) step();
        checks++;
        if (wlog.size() != 5) begin
            errors++; $display("FAIL full_count writes=%0d exp=5", wlog.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wlog[i] !== {15'h0300 + 15'(i), 8'h40 + 8'(i)}) begin
                    errors++; $display("FAIL full_order%0d got=%h exp=%h", i, wlog[i], {15'h0300 + 15'(i), 8'h40 + 8'(i)});
                end
            end
        end
    endtask

    task automatic test_reset_mid_queue();
        disp_active = 1'b1; pix_en = 1'b1; scan_addr = 15'h0011;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_addr = 15'h0500 + 15'(k); wr_data = 8'h70 + 8'(k);
            step();
        end
        wr_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_fill lvl=%0d exp=3", fifo_level); end
        step();
        step();                       // pix_valid high now from the scans
        #3 Reset = 1'b1;
        #1;
        checks++;
        if (fifo_level !== 3'd0 || wr_ready !== 1'b1 || mem_we !== 1'b0 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset lvl=%0d rdy=%b we=%b pv=%b exp 0/1/0/0", fifo_level, wr_ready, mem_we, pix_valid);
        end
        #2 Reset = 1'b0;
        pix_en = 1'b0; disp_active = 1'b0;
        wlog.delete();
        repeat (5) step();
        checks++;
        if (wlog.size() != 0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL mid_discard writes=%0d lvl=%0d exp 0/0", wlog.size(), fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_scan_read();
        test_scan_priority();
        test_interleave();
        test_full();
        test_reset_mid_queue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
